// File: rtl/cla28_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla28_pipe_adder
// Brief    : 3-stage pipelined carry-lookahead adder (group P/G -> group
//            carries -> sum) with valid/ready handshakes on both sides.
//            Define CLA_OVF_EN to add the registered signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module cla28_pipe_adder #(
    parameter int WIDTH = 28,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CLA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NGRP = WIDTH / GROUP;

    logic             v1_q, v2_q, v3_q;
    logic             v1_d, v2_d, v3_d;
    logic             w_rdy2, w_rdy3;
    logic             w_ld1, w_ld2, w_ld3;

    logic [WIDTH-1:0] w_p, w_g, w_x;
    logic [NGRP-1:0]  w_gp, w_gg;
    logic             w_t1, w_acc1;

    logic [WIDTH-1:0] x1_q, p1_q, g1_q;
    logic [NGRP-1:0]  gp1_q, gg1_q;
    logic             cin1_q;

    logic [NGRP:0]    gc_d;
    logic             w_t2, w_acc2;

    logic [WIDTH-1:0] x2_q, p2_q, g2_q;
    logic [NGRP:0]    gc2_q;

    logic [WIDTH-1:0] w_c;
    logic             w_cc;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    // A stage accepts when empty or when its current contents leave this cycle.
    assign w_rdy3   = !v3_q | out_ready;
    assign w_rdy2   = !v2_q | w_rdy3;
    assign in_ready = !v1_q | w_rdy2;

    assign w_ld1 = in_valid & in_ready;
    assign w_ld2 = v1_q & w_rdy2;
    assign w_ld3 = v2_q & w_rdy3;

    assign v1_d = in_ready ? in_valid : v1_q;
    assign v2_d = w_rdy2   ? v1_q     : v2_q;
    assign v3_d = w_rdy3   ? v2_q     : v3_q;

    assign w_p = a | b;
    assign w_g = a & b;
    assign w_x = a ^ b;

    always_comb begin
        w_gp   = '0;
        w_gg   = '0;
        w_t1   = 1'b0;
        w_acc1 = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            w_gp[k] = &w_p[k*GROUP +: GROUP];
            w_acc1  = 1'b0;
            for (int j = 0; j < GROUP; j++) begin
                w_t1 = w_g[k*GROUP + j];
                for (int m = j + 1; m < GROUP; m++) begin
                    w_t1 = w_t1 & w_p[k*GROUP + m];
                end
                w_acc1 = w_acc1 | w_t1;
            end
            w_gg[k] = w_acc1;
        end
    end

    // Each group carry is expanded directly in terms of cin, so no ripple across groups.
    always_comb begin
        gc_d    = '0;
        w_t2    = 1'b0;
        w_acc2  = 1'b0;
        gc_d[0] = cin1_q;
        for (int k = 1; k <= NGRP; k++) begin
            w_acc2 = cin1_q;
            for (int m = 0; m < k; m++) begin
                w_acc2 = w_acc2 & gp1_q[m];
            end
            for (int j = 0; j < k; j++) begin
                w_t2 = gg1_q[j];
                for (int m = j + 1; m < k; m++) begin
                    w_t2 = w_t2 & gp1_q[m];
                end
                w_acc2 = w_acc2 | w_t2;
            end
            gc_d[k] = w_acc2;
        end
    end

    always_comb begin
        w_c  = '0;
        w_cc = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            w_cc = gc2_q[k];
            for (int j = 0; j < GROUP; j++) begin
                w_c[k*GROUP + j] = w_cc;
                w_cc = g2_q[k*GROUP + j] | (p2_q[k*GROUP + j] & w_cc);
            end
        end
    end

    assign sum_d  = x2_q ^ w_c;
    assign cout_d = gc2_q[NGRP];

`ifdef CLA_OVF_EN
    logic ovf_d, ovf_q;
    assign ovf_d = w_c[WIDTH-1] ^ gc2_q[NGRP];
    assign ovf   = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            x1_q   <= '0;
            p1_q   <= '0;
            g1_q   <= '0;
            gp1_q  <= '0;
            gg1_q  <= '0;
            cin1_q <= 1'b0;
            x2_q   <= '0;
            p2_q   <= '0;
            g2_q   <= '0;
            gc2_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef CLA_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (w_ld1) begin
                x1_q   <= w_x;
                p1_q   <= w_p;
                g1_q   <= w_g;
                gp1_q  <= w_gp;
                gg1_q  <= w_gg;
                cin1_q <= cin;
            end
            if (w_ld2) begin
                x2_q  <= x1_q;
                p2_q  <= p1_q;
                g2_q  <= g1_q;
                gc2_q <= gc_d;
            end
            if (w_ld3) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
`ifdef CLA_OVF_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign out_valid = v3_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
`default_nettype wire
